// File: rtl/adc_code_hist_pkg.sv
// Shared definitions for the code-density histogram and the UART TX that reads it out.
package adc_code_hist_pkg;

    localparam int HIST_WIDTH_DATA  = 16;
    localparam int HIST_LENGTH_ADDR = 10;
    localparam int HIST_CNT_WIDTH   = 24;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ACQ   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } hist_state_t;

endpackage

// File: rtl/hist_dpram.sv
// Simple dual-port bin RAM: one write port, one synchronous read-first read port.
module hist_dpram #(
    parameter int WIDTH_DATA  = 16,
    parameter int LENGTH_ADDR = 10
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [LENGTH_ADDR-1:0] waddr,
    input  logic [WIDTH_DATA-1:0]  wdata,
    input  logic [LENGTH_ADDR-1:0] raddr,
    output logic [WIDTH_DATA-1:0]  rdata
);
    localparam int DEPTH = 1 << LENGTH_ADDR;

    logic [WIDTH_DATA-1:0] mem [DEPTH];

    // A same-cycle read of the written bin returns the old contents.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/adc_code_hist.sv
// Code-density histogram: bins every accepted ADC sample into a per-code counter RAM
// and exposes the finished histogram through a 1-cycle-latency read port.
module adc_code_hist
    import adc_code_hist_pkg::*;
#(
    parameter int WIDTH_DATA  = HIST_WIDTH_DATA,
    parameter int LENGTH_ADDR = HIST_LENGTH_ADDR,
    parameter int CNT_WIDTH   = HIST_CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LENGTH_ADDR-1:0] adc_code,
    input  logic                   adc_valid,
    output logic                   adc_ready,
    input  logic [CNT_WIDTH-1:0]   n_samples,
    input  logic                   acq_start,
    input  logic                   clr_start,
    input  logic [LENGTH_ADDR-1:0] rd_addr,
    output logic [WIDTH_DATA-1:0]  rd_data,
    output logic                   busy,
    output logic                   hist_done,
    output logic                   hist_valid,
    output logic                   sat_flag
);
    hist_state_t            state;
    logic [LENGTH_ADDR-1:0] clr_idx;
    logic [CNT_WIDTH-1:0]   target;
    logic [CNT_WIDTH-1:0]   sample_cnt;
    logic                   drain_cnt;
    logic                   rd_valid;
    logic                   accept;

    logic                   v_s1;
    logic [LENGTH_ADDR-1:0] code_s1;
    logic                   last_wr_v;
    logic [LENGTH_ADDR-1:0] last_wr_code;
    logic [WIDTH_DATA-1:0]  last_wr_val;
    logic [WIDTH_DATA-1:0]  ram_q;
    logic [WIDTH_DATA-1:0]  old_val;
    logic [WIDTH_DATA-1:0]  new_val;
    logic                   fwd;
    logic                   old_sat;
    logic                   sat_hit;

    logic                   ram_we;
    logic [LENGTH_ADDR-1:0] ram_waddr;
    logic [WIDTH_DATA-1:0]  ram_wdata;
    logic [LENGTH_ADDR-1:0] ram_raddr;

    assign adc_ready = (state == ST_ACQ) && (sample_cnt != target);
    assign accept    = adc_valid && adc_ready;
    assign busy      = (state == ST_CLEAR) || (state == ST_ACQ) || (state == ST_DRAIN);
    assign rd_data   = rd_valid ? ram_q : '0;

    // S2: the previous cycle's write to the same bin is not yet visible in ram_q.
    assign fwd     = last_wr_v && (last_wr_code == code_s1);
    assign old_val = fwd ? last_wr_val : ram_q;
    assign old_sat = (old_val == '1);
    assign new_val = old_sat ? old_val : old_val + 1'b1;
    assign sat_hit = v_s1 && old_sat;

    assign ram_raddr = (state == ST_DONE) ? rd_addr : adc_code;

    always_comb begin
        ram_we    = v_s1;
        ram_waddr = code_s1;
        ram_wdata = new_val;
        if (state == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_idx;
            ram_wdata = '0;
        end
    end

    hist_dpram #(
        .WIDTH_DATA (WIDTH_DATA),
        .LENGTH_ADDR(LENGTH_ADDR)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(ram_raddr),
        .rdata(ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v_s1      <= 1'b0;
            last_wr_v <= 1'b0;
        end else begin
            v_s1      <= accept;
            last_wr_v <= v_s1;
        end
        code_s1      <= adc_code;
        last_wr_code <= code_s1;
        last_wr_val  <= new_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_CLEAR;
            clr_idx    <= '0;
            target     <= '0;
            sample_cnt <= '0;
            drain_cnt  <= 1'b0;
            rd_valid   <= 1'b0;
            hist_done  <= 1'b0;
            hist_valid <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            hist_done <= 1'b0;
            rd_valid  <= 1'b0;
            if (sat_hit) sat_flag <= 1'b1;
            unique case (state)
                ST_CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == '1) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (clr_start) begin
                        state    <= ST_CLEAR;
                        clr_idx  <= '0;
                        sat_flag <= 1'b0;
                    end else if (acq_start) begin
                        state      <= ST_ACQ;
                        target     <= n_samples;
                        sample_cnt <= '0;
                    end
                end
                ST_ACQ: begin
                    if (accept) sample_cnt <= sample_cnt + 1'b1;
                    if (sample_cnt == target) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                // Two cycles let the last sample's S2 write reach the RAM.
                ST_DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state      <= ST_DONE;
                        hist_done  <= 1'b1;
                        hist_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (clr_start) begin
                        state      <= ST_CLEAR;
                        clr_idx    <= '0;
                        sat_flag   <= 1'b0;
                        hist_valid <= 1'b0;
                    end else begin
                        rd_valid <= 1'b1;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_code_hist.sv
// Randomized self-checking bench for adc_code_hist against an array-based histogram model.
module tb_adc_code_hist;
    localparam int LA   = 4;
    localparam int WD   = 4;
    localparam int CW   = 8;
    localparam int NB   = 16;
    localparam int MAXV = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [LA-1:0] adc_code;
    logic          adc_valid;
    logic          adc_ready;
    logic [CW-1:0] n_samples;
    logic          acq_start;
    logic          clr_start;
    logic [LA-1:0] rd_addr;
    logic [WD-1:0] rd_data;
    logic          busy;
    logic          hist_done;
    logic          hist_valid;
    logic          sat_flag;

    int            tests  = 0;
    int            errors = 0;
    int            model_bins [NB];
    bit            model_sat;
    logic [WD-1:0] obs_bins [NB];
    int            stream_codes [$];

    adc_code_hist #(
        .WIDTH_DATA (WD),
        .LENGTH_ADDR(LA),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .adc_code  (adc_code),
        .adc_valid (adc_valid),
        .adc_ready (adc_ready),
        .n_samples (n_samples),
        .acq_start (acq_start),
        .clr_start (clr_start),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .hist_done (hist_done),
        .hist_valid(hist_valid),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int b = 0; b < NB; b++) model_bins[b] = 0;
        model_sat = 1'b0;
    endtask

    task automatic model_add(input int code);
        if (model_bins[code] == MAXV) model_sat = 1'b1;
        else model_bins[code] = model_bins[code] + 1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic pulse_acq(input int n);
        n_samples = CW'(n);
        acq_start = 1'b1;
        tick();
        acq_start = 1'b0;
    endtask

    task automatic clear_and_wait(output int n);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        count_busy(n);
        model_clear();
    endtask

    // Feeds stream_codes; the model alone decides which cycles must be accepted.
    task automatic drive_stream(input int n, input int gap_pct, output int ready_errs);
        int idx = 0;
        int cnt = 0;
        int extra = 0;
        int code;
        bit mready;
        ready_errs = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            mready = (cnt < n);
            if (adc_ready !== mready) ready_errs++;
            if (!mready) begin
                if (extra == 3) break;
                extra++;
            end
            code = (idx < stream_codes.size()) ? stream_codes[idx] : int'($urandom_range(NB - 1));
            adc_valid = (int'($urandom_range(99)) >= gap_pct) || !mready;
            adc_code  = code[LA-1:0];
            if (adc_valid && mready) begin
                model_add(code);
                cnt++;
                idx++;
            end
            tick();
        end
        adc_valid = 1'b0;
        if (cnt != n) ready_errs++;
    endtask

    task automatic wait_done(output int pulses, output bit timed_out);
        pulses = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (hist_done === 1'b1) pulses++;
            if (hist_valid === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (hist_done === 1'b1) pulses++;
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < NB; a++) begin
            rd_addr = LA'(a);
            tick();
            obs_bins[a] = rd_data;
        end
    endtask

    task automatic run_acq(input int n, input int gap_pct, output int ready_errs,
                           output int pulses, output bit timed_out);
        pulse_acq(n);
        drive_stream(n, gap_pct, ready_errs);
        wait_done(pulses, timed_out);
    endtask

    task automatic test_reset();
        int n;
        int re;
        int p;
        bit to;
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if (adc_ready !== 1'b0 || hist_done !== 1'b0 || hist_valid !== 1'b0 ||
            rd_data !== '0 || busy !== 1'b1 || sat_flag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got ready=%b done=%b valid=%b rd=%0d busy=%b sat=%b, expected 0 0 0 0 1 0",
                     adc_ready, hist_done, hist_valid, rd_data, busy, sat_flag);
        end
        rst = 1'b0;
        count_busy(n);
        tests++;
        if (n != 16) begin
            errors++;
            $display("[TB] FAIL reset_clear_cycles: got %0d busy cycles, expected 16", n);
        end
        model_clear();
        tests++;
        if (rd_data !== '0 || hist_valid !== 1'b0 || adc_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_outputs: got rd=%0d valid=%b ready=%b, expected 0 0 0",
                     rd_data, hist_valid, adc_ready);
        end
        run_acq(0, 0, re, p, to);
        tests++;
        if (re != 0 || p != 1 || to) begin
            errors++;
            $display("[TB] FAIL zero_acq: got ready_errs=%0d pulses=%0d timeout=%b, expected 0 1 0", re, p, to);
        end
        read_all();
        for (int b = 0; b < NB; b++) begin
            tests++;
            if (obs_bins[b] !== '0) begin
                errors++;
                $display("[TB] FAIL zero_acq_bin%0d: got %0d expected 0", b, obs_bins[b]);
            end
        end
        clear_and_wait(n);
    endtask

    task automatic test_basic_and_readout();
        int n;
        int re;
        int p;
        bit to;
        stream_codes = '{3, 7, 3, 0, 15};
        run_acq(5, 0, re, p, to);
        tests++;
        if (re != 0 || p != 1 || to) begin
            errors++;
            $display("[TB] FAIL basic_acq: got ready_errs=%0d pulses=%0d timeout=%b, expected 0 1 0", re, p, to);
        end
        read_all();
        for (int b = 0; b < NB; b++) begin
            tests++;
            if (obs_bins[b] !== WD'(model_bins[b])) begin
                errors++;
                $display("[TB] FAIL basic_bin%0d: got %0d expected %0d", b, obs_bins[b], model_bins[b]);
            end
        end
        rd_addr = 4'd3;
        tick();
        rd_addr = 4'd7;
        tests++;
        if (rd_data !== 4'd2) begin
            errors++;
            $display("[TB] FAIL latency_before: got %0d expected 2", rd_data);
        end
        tick();
        tests++;
        if (rd_data !== 4'd1) begin
            errors++;
            $display("[TB] FAIL latency_after: got %0d expected 1", rd_data);
        end
        adc_code  = 4'd7;
        adc_valid = 1'b1;
        acq_start = 1'b1;
        repeat (5) tick();
        adc_valid = 1'b0;
        acq_start = 1'b0;
        read_all();
        for (int b = 0; b < NB; b++) begin
            tests++;
            if (obs_bins[b] !== WD'(model_bins[b])) begin
                errors++;
                $display("[TB] FAIL done_ignore_bin%0d: got %0d expected %0d", b, obs_bins[b], model_bins[b]);
            end
        end
        tests++;
        if (hist_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_hold: got hist_valid=%b expected 1", hist_valid);
        end
        clear_and_wait(n);
    endtask

    task automatic test_back_to_back();
        int n;
        int re;
        int p;
        bit to;
        for (int pass = 0; pass < 2; pass++) begin
            stream_codes = '{9, 9, 9, 9};
            run_acq(4, (pass == 0) ? 0 : 50, re, p, to);
            read_all();
            tests++;
            if (re != 0 || p != 1 || to || obs_bins[9] !== 4'd4) begin
                errors++;
                $display("[TB] FAIL b2b_pass%0d: got ready_errs=%0d pulses=%0d timeout=%b bin9=%0d, expected 0 1 0 4",
                         pass, re, p, to, obs_bins[9]);
            end
            clear_and_wait(n);
        end
    endtask

    task automatic test_saturation();
        int n;
        int re;
        int p;
        bit to;
        stream_codes.delete();
        for (int i = 0; i < 20; i++) stream_codes.push_back(2);
        run_acq(20, 0, re, p, to);
        read_all();
        tests++;
        if (re != 0 || p != 1 || obs_bins[2] !== WD'(model_bins[2]) || sat_flag !== model_sat) begin
            errors++;
            $display("[TB] FAIL saturate: got ready_errs=%0d pulses=%0d bin2=%0d sat=%b, expected 0 1 %0d %b",
                     re, p, obs_bins[2], sat_flag, model_bins[2], model_sat);
        end
        clear_and_wait(n);
        tests++;
        if (sat_flag !== 1'b0 || n != 16) begin
            errors++;
            $display("[TB] FAIL sat_clear: got sat=%b clear_cycles=%0d, expected 0 16", sat_flag, n);
        end
        run_acq(0, 0, re, p, to);
        read_all();
        for (int b = 0; b < NB; b++) begin
            tests++;
            if (obs_bins[b] !== '0) begin
                errors++;
                $display("[TB] FAIL sat_clear_bin%0d: got %0d expected 0", b, obs_bins[b]);
            end
        end
        clear_and_wait(n);
    endtask

    task automatic test_clr_priority();
        int n;
        n_samples = 8'd5;
        acq_start = 1'b1;
        clr_start = 1'b1;
        tick();
        acq_start = 1'b0;
        clr_start = 1'b0;
        tests++;
        if (busy !== 1'b1 || adc_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_priority_state: got busy=%b ready=%b, expected 1 0", busy, adc_ready);
        end
        count_busy(n);
        tests++;
        if (n != 16) begin
            errors++;
            $display("[TB] FAIL clr_priority_cycles: got %0d expected 16", n);
        end
    endtask

    task automatic test_reset_mid_acq();
        int n;
        int re;
        int p;
        bit to;
        pulse_acq(10);
        adc_code  = 4'd5;
        adc_valid = 1'b1;
        repeat (3) tick();
        rst       = 1'b1;
        adc_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        count_busy(n);
        model_clear();
        tests++;
        if (n != 16) begin
            errors++;
            $display("[TB] FAIL mid_acq_reset_cycles: got %0d expected 16", n);
        end
        run_acq(0, 0, re, p, to);
        read_all();
        for (int b = 0; b < NB; b++) begin
            tests++;
            if (obs_bins[b] !== '0) begin
                errors++;
                $display("[TB] FAIL mid_acq_reset_bin%0d: got %0d expected 0", b, obs_bins[b]);
            end
        end
        clear_and_wait(n);
    endtask

    task automatic test_random();
        int n;
        int ns;
        int re;
        int p;
        bit to;
        for (int it = 0; it < 6; it++) begin
            ns = int'($urandom_range(40, 1));
            stream_codes.delete();
            for (int i = 0; i < ns; i++) stream_codes.push_back(int'($urandom_range(NB - 1)));
            run_acq(ns, 30, re, p, to);
            tests++;
            if (re != 0 || p != 1 || to || sat_flag !== model_sat) begin
                errors++;
                $display("[TB] FAIL rand%0d_ctrl: got ready_errs=%0d pulses=%0d timeout=%b sat=%b, expected 0 1 0 %b",
                         it, re, p, to, sat_flag, model_sat);
            end
            read_all();
            for (int b = 0; b < NB; b++) begin
                tests++;
                if (obs_bins[b] !== WD'(model_bins[b])) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_bin%0d: got %0d expected %0d", it, b, obs_bins[b], model_bins[b]);
                end
            end
            clear_and_wait(n);
        end
    endtask

    initial begin
        rst       = 1'b1;
        adc_code  = '0;
        adc_valid = 1'b0;
        n_samples = '0;
        acq_start = 1'b0;
        clr_start = 1'b0;
        rd_addr   = '0;
        model_clear();
        test_reset();
        test_basic_and_readout();
        test_back_to_back();
        test_saturation();
        test_clr_priority();
        test_reset_mid_acq();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
